// File: rtl/rtl_seq_gen_pkg.sv
// ============================================================================
// Module  : seq_gen_pkg
// Brief   : Shared types and constants for the rtl_seq_gen serial sequence source.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_gen_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } seq_state_t;

    localparam int          LFSR_W      = 8;
    localparam logic [7:0]  LFSR_TAPS   = 8'hB8;
    localparam int          DEF_PAT_LEN = 8;
    localparam logic [31:0] DEF_PATTERN = 32'b1011_0010;

    // An all-zero LFSR state would lock up, so a zero seed falls back to 1.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] seed);
        return (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rtl_seq_gen_if.sv
// ============================================================================
// Module  : rtl_seq_gen_if
// Brief   : Serial output bundle between the sequence source and its consumer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rtl_seq_gen_if;
    logic y;

    modport master (output y);
    modport slave  (input  y);
endinterface

`default_nettype wire

// File: rtl/rtl_seq_gen_lfsr.sv
// ============================================================================
// Module  : seq_gen_lfsr
// Brief   : 8-bit Fibonacci LFSR (taps 7,5,4,3); bit_o is the MSB before shift.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_gen_lfsr
    import seq_gen_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              en,
    input  wire logic [LFSR_W-1:0] seed,
    output logic                   bit_o
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = {q_q[LFSR_W-2:0], ^(q_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= seed_fix(seed);
        end else begin
            q_q <= q_d;
        end
    end

    assign bit_o = q_q[LFSR_W-1];

endmodule

`default_nettype wire

// File: rtl/rtl_seq_gen.sv
// ============================================================================
// Module  : rtl_seq_gen
// Brief   : Autonomous serial sequence generator: start delay, then a repeating
//           MSB-first pattern. Define SEQ_GEN_LFSR_EN for an LFSR stream instead.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rtl_seq_gen
    import seq_gen_pkg::*;
#(
    parameter int          PAT_LEN     = DEF_PAT_LEN,
    parameter logic [31:0] PATTERN     = DEF_PATTERN,
    parameter int          START_DELAY = 2,
    parameter logic [7:0]  LFSR_SEED   = 8'h01
) (
    input  wire logic clk,
    input  wire logic reset,
    output logic      y
);

    localparam logic [7:0] DLY     = 8'(START_DELAY);
    localparam logic [4:0] IDX_MSB = 5'(PAT_LEN - 1);

    seq_state_t state_q, state_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic       y_q, y_d;
    logic       w_start;
    logic       w_bit;

    assign w_start = (state_q == S_IDLE) && (dcnt_q == DLY);

`ifdef SEQ_GEN_LFSR_EN
    logic w_emit;

    // Shift on every edge that emits a bit, including the IDLE->RUN edge.
    assign w_emit = (state_d == S_RUN);

    seq_gen_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (w_emit),
        .seed  (LFSR_SEED),
        .bit_o (w_bit)
    );
`else
    logic [4:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (w_start) begin
            idx_d = IDX_MSB - 5'd1;
        end else if (state_q == S_RUN) begin
            idx_d = (idx_q == 5'd0) ? IDX_MSB : idx_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= IDX_MSB;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign w_bit = (state_q == S_IDLE) ? PATTERN[IDX_MSB] : PATTERN[idx_q];
`endif

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        y_d     = y_q;
        unique case (state_q)
            S_IDLE: begin
                y_d = 1'b0;
                if (w_start) begin
                    state_d = S_RUN;
                    y_d     = w_bit;
                end else begin
                    dcnt_d = dcnt_q + 8'd1;
                end
            end
            S_RUN: begin
                y_d = w_bit;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dcnt_q  <= 8'd0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            y_q     <= y_d;
        end
    end

    assign y = y_q;

endmodule

`default_nettype wire

// File: tb/tb_rtl_seq_gen.sv
// ============================================================================
// Module  : tb_rtl_seq_gen
// Brief   : Self-checking bench for rtl_seq_gen (pattern mode, or LFSR mode when
//           SEQ_GEN_LFSR_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtl_seq_gen;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int k           = 0;     // edges since reset was last released

    localparam logic [7:0] REF_PAT = 8'b1011_0010;
    logic lfsr_seq [255];

    always #5 clk = ~clk;

    rtl_seq_gen_if sif0 ();
    rtl_seq_gen_if sif1 ();
    rtl_seq_gen_if sif2 ();

    rtl_seq_gen #(.PAT_LEN(8), .PATTERN(32'hB2), .START_DELAY(2), .LFSR_SEED(8'h01)) u_d0 (
        .clk(clk), .reset(reset), .y(sif0.y));
    rtl_seq_gen #(.PAT_LEN(8), .PATTERN(32'hB2), .START_DELAY(0), .LFSR_SEED(8'h01)) u_d1 (
        .clk(clk), .reset(reset), .y(sif1.y));
    rtl_seq_gen #(.PAT_LEN(8), .PATTERN(32'hB2), .START_DELAY(2), .LFSR_SEED(8'h00)) u_d2 (
        .clk(clk), .reset(reset), .y(sif2.y));

    // Expected y on edge kk after release, for a given start delay.
    function automatic logic exp_y(input int kk, input int sd);
        int m;
        if (kk <= sd) return 1'b0;
        m = kk - sd - 1;
`ifdef SEQ_GEN_LFSR_EN
        return lfsr_seq[m % 255];
`else
        return REF_PAT[7 - (m % 8)];
`endif
    endfunction

    task automatic tick();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        if (r) k = 0;
        else   k = k + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sif0.y !== 1'b0) begin miscompares++; $display("FAIL reset d0 cyc=%0d got=%b exp=0", i, sif0.y); end
            if (sif1.y !== 1'b0) begin miscompares++; $display("FAIL reset d1 cyc=%0d got=%b exp=0", i, sif1.y); end
            if (sif2.y !== 1'b0) begin miscompares++; $display("FAIL reset d2 cyc=%0d got=%b exp=0", i, sif2.y); end
            vectors += 3;
        end
    endtask

    task automatic test_pattern();
        reset = 1'b0;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (sif0.y !== exp_y(k, 2)) begin miscompares++; $display("FAIL pattern d0 k=%0d got=%b exp=%b", k, sif0.y, exp_y(k, 2)); end
            if (sif1.y !== exp_y(k, 0)) begin miscompares++; $display("FAIL pattern d1 k=%0d got=%b exp=%b", k, sif1.y, exp_y(k, 0)); end
            if (sif2.y !== exp_y(k, 2)) begin miscompares++; $display("FAIL pattern d2 k=%0d got=%b exp=%b", k, sif2.y, exp_y(k, 2)); end
            vectors += 3;
        end
    endtask

    task automatic test_midrun_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            reset = (i == 7) ? 1'b1 : 1'b0;    // 5 edges into the run
            tick();
            if (sif0.y !== exp_y(k, 2)) begin miscompares++; $display("FAIL midrun d0 k=%0d got=%b exp=%b", k, sif0.y, exp_y(k, 2)); end
            if (sif1.y !== exp_y(k, 0)) begin miscompares++; $display("FAIL midrun d1 k=%0d got=%b exp=%b", k, sif1.y, exp_y(k, 0)); end
            if (sif2.y !== exp_y(k, 2)) begin miscompares++; $display("FAIL midrun d2 k=%0d got=%b exp=%b", k, sif2.y, exp_y(k, 2)); end
            vectors += 3;
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        int run_len;
        int rst_len;
        for (int it = 0; it < 30; it++) begin
            run_len = int'($urandom_range(1, 40));
            rst_len = int'($urandom_range(1, 3));
            for (int i = 0; i < run_len + rst_len; i++) begin
                reset = (i >= run_len) ? 1'b1 : 1'b0;
                tick();
                if (sif0.y !== exp_y(k, 2)) begin miscompares++; $display("FAIL random d0 it=%0d k=%0d got=%b exp=%b", it, k, sif0.y, exp_y(k, 2)); end
                if (sif1.y !== exp_y(k, 0)) begin miscompares++; $display("FAIL random d1 it=%0d k=%0d got=%b exp=%b", it, k, sif1.y, exp_y(k, 0)); end
                if (sif2.y !== exp_y(k, 2)) begin miscompares++; $display("FAIL random d2 it=%0d k=%0d got=%b exp=%b", it, k, sif2.y, exp_y(k, 2)); end
                vectors += 3;
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_long_run();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (sif0.y !== exp_y(k, 2)) begin miscompares++; $display("FAIL long d0 k=%0d got=%b exp=%b", k, sif0.y, exp_y(k, 2)); end
            if (sif1.y !== exp_y(k, 0)) begin miscompares++; $display("FAIL long d1 k=%0d got=%b exp=%b", k, sif1.y, exp_y(k, 0)); end
            if (sif2.y !== exp_y(k, 2)) begin miscompares++; $display("FAIL long d2 k=%0d got=%b exp=%b", k, sif2.y, exp_y(k, 2)); end
            vectors += 3;
        end
    endtask

    initial begin
        logic [7:0] q;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            lfsr_seq[i] = q[7];
            q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end

        test_reset();
        test_pattern();
        test_midrun_reset();
        test_reset();
        test_pattern();
        test_random();
        test_long_run();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
